// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the single SDRAM slave port.
// Master 0 is the image writer and master 1 is the VGA frame reader.
// Grants are round-robin and last for a whole bus cycle (cyc high).
// Exactly one idle cycle separates two owners.
// The datapath and the response routing are decoded combinationally from the registered state.
module wshb_arbiter #(
  parameter int ADR_W      = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  // master 0 (image writer)
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADR_W-1:0]        m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,
  // master 1 (VGA reader)
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADR_W-1:0]        m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,
  // SDRAM slave side
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADR_W-1:0]        s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,
  // current owner, one-hot, 00 = bus idle
  output logic [1:0]              gnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;

  state_t state_r;
  state_t state_s;
  // last_r = 1'b1 means master 1 was the most recent owner, so master 0 wins the next tie
  logic   last_r;
  logic   last_s;

  // State and round-robin history registers; reset abandons any in-flight cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
    end
  end

  // Next-state logic: grant from IDLE only, release when the owner drops cyc
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_cyc && (!m1_cyc || last_r)) begin
          state_s = ST_GNT0;
        end else if (m1_cyc) begin
          state_s = ST_GNT1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GNT0: begin
        if (m0_cyc) begin
          state_s = ST_GNT0;
        end else begin
          state_s = ST_IDLE;
          last_s  = 1'b0;
        end
      end
      ST_GNT1: begin
        if (m1_cyc) begin
          state_s = ST_GNT1;
        end else begin
          state_s = ST_IDLE;
          last_s  = 1'b1;
        end
      end
      default: begin
        // unreachable encoding: recover to IDLE
        state_s = ST_IDLE;
        last_s  = last_r;
      end
    endcase
  end

  // Bus multiplexer and response gating decoded from the registered owner
  always_comb begin
    gnt      = 2'b00;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = {ADR_W{1'b0}};
    s_dat_ms = {(8*DATA_BYTES){1'b0}};
    s_sel    = {DATA_BYTES{1'b0}};
    s_cti    = 3'b000;
    s_bte    = 2'b00;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rty   = 1'b0;
    case (state_r)
      ST_GNT0: begin
        gnt      = 2'b01;
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        m0_err   = s_err;
        m0_rty   = s_rty;
      end
      ST_GNT1: begin
        gnt      = 2'b10;
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        m1_err   = s_err;
        m1_rty   = s_rty;
      end
      default: begin
        // IDLE and unreachable encodings: bus quiet, no responses routed
        gnt = 2'b00;
      end
    endcase
  end

  // Read data is broadcast; only the owner gets ack, so the other master ignores it
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule
